// File: rtl/led_breath_multi.sv
// led_breath_multi: multi-channel breathing-LED PWM engine.
//   A shared 1 us prescaler, PWM frame counter and triangle brightness generator feed CH
//   channels. Each channel picks off / on / breathe / inverted breathe from its mode bits.
//   Mode bits are shadowed and only reloaded at frame boundaries, so a frame is never cut.
// Ports:
//   s_clk       system clock
//   s_rst       asynchronous, active-high reset
//   en          engine enable; 0 clears the engine synchronously and turns all LEDs off
//   mode        per-channel mode, channel i in mode[2i+1:2i]
//               (00 off, 01 on, 10 breathe, 11 inverted breathe)
//   led         registered LED pins, LED_ON_LVL lights an LED
//   cycle_done  one-clock pulse when a full up/down breath cycle completes
module led_breath_multi #(
    parameter int unsigned CH         = 4,
    parameter int unsigned CLK_PER_US = 34,
    parameter int unsigned STEPS      = 1000,
    parameter logic        LED_ON_LVL = 1'b0
) (
    input  logic            s_clk,
    input  logic            s_rst,
    input  logic            en,
    input  logic [2*CH-1:0] mode,
    output logic [CH-1:0]   led,
    output logic            cycle_done
);

    localparam int unsigned PSC_W  = $clog2(CLK_PER_US);
    localparam int unsigned CNT_W  = $clog2(STEPS);
    // Duty must also represent STEPS (always lit), hence one more code than the counter.
    localparam int unsigned DUTY_W = $clog2(STEPS + 1);

    localparam logic [PSC_W-1:0]  PSC_LAST  = PSC_W'(CLK_PER_US - 1);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(STEPS - 1);
    // Level from which the next up-step lands on the top value.
    localparam logic [CNT_W-1:0]  LVL_PEAK1 = CNT_W'(STEPS - 2);
    localparam logic [DUTY_W-1:0] DUTY_FULL = DUTY_W'(STEPS);

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

    localparam logic [CH-1:0] LED_ALL_OFF = {CH{~LED_ON_LVL}};

    logic [PSC_W-1:0]  psc_q, psc_d;
    logic [CNT_W-1:0]  pwm_cnt_q, pwm_cnt_d;
    logic [CNT_W-1:0]  level_q, level_d;
    logic              dir_q, dir_d;
    logic [2*CH-1:0]   mode_sh_q, mode_sh_d;
    logic [CH-1:0]     led_q, led_d;
    logic              cycle_done_q, cycle_done_d;

    logic              tick;
    logic              frame_end;
    logic [DUTY_W-1:0] duty [CH];
    logic [CH-1:0]     lit;

    assign tick      = (psc_q == PSC_LAST);
    assign frame_end = tick && (pwm_cnt_q == CNT_LAST);

    // Per-channel duty from the shadowed mode, compared against the live frame position.
    always_comb begin
        for (int i = 0; i < CH; i++) begin
            duty[i] = '0;
            unique case (mode_sh_q[2*i +: 2])
                2'b00: duty[i] = '0;
                2'b01: duty[i] = DUTY_FULL;
                2'b10: duty[i] = DUTY_W'(level_q);
                2'b11: duty[i] = DUTY_W'(CNT_LAST - level_q);
                default: duty[i] = '0;
            endcase
            lit[i] = (DUTY_W'(pwm_cnt_q) < duty[i]);
        end
    end

    always_comb begin
        psc_d        = psc_q;
        pwm_cnt_d    = pwm_cnt_q;
        level_d      = level_q;
        dir_d        = dir_q;
        mode_sh_d    = mode_sh_q;
        led_d        = LED_ALL_OFF;
        cycle_done_d = 1'b0;

        if (!en) begin
            psc_d     = '0;
            pwm_cnt_d = '0;
            level_d   = '0;
            dir_d     = DIR_UP;
            mode_sh_d = mode;
        end else begin
            psc_d = tick ? '0 : psc_q + PSC_W'(1);
            if (tick) begin
                pwm_cnt_d = (pwm_cnt_q == CNT_LAST) ? '0 : pwm_cnt_q + CNT_W'(1);
            end
            if (frame_end) begin
                mode_sh_d = mode;
                if (dir_q == DIR_UP) begin
                    level_d = level_q + CNT_W'(1);
                    if (level_q == LVL_PEAK1) begin
                        dir_d = DIR_DOWN;
                    end
                end else begin
                    level_d = level_q - CNT_W'(1);
                    if (level_q == CNT_W'(1)) begin
                        dir_d        = DIR_UP;
                        cycle_done_d = 1'b1;
                    end
                end
            end
            for (int i = 0; i < CH; i++) begin
                led_d[i] = lit[i] ? LED_ON_LVL : ~LED_ON_LVL;
            end
        end
    end

    always_ff @(posedge s_clk or posedge s_rst) begin
        if (s_rst) begin
            psc_q        <= '0;
            pwm_cnt_q    <= '0;
            level_q      <= '0;
            dir_q        <= DIR_UP;
            mode_sh_q    <= '0;
            led_q        <= LED_ALL_OFF;
            cycle_done_q <= 1'b0;
        end else begin
            psc_q        <= psc_d;
            pwm_cnt_q    <= pwm_cnt_d;
            level_q      <= level_d;
            dir_q        <= dir_d;
            mode_sh_q    <= mode_sh_d;
            led_q        <= led_d;
            cycle_done_q <= cycle_done_d;
        end
    end

    assign led        = led_q;
    assign cycle_done = cycle_done_q;

endmodule
